fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction prefetch FIFO that sits between the PC/instruction-fetch stage and decode.
//   It decouples fetch from decode stalls by buffering up to DEPTH fetched entries.
//   Each entry holds {pc, instr, except, delayslot}.
//   A single-cycle flush empties the queue on branch/jump redirect or exception trap (pc_trapM).
// PARAMETERS
//   DEPTH   4   number of entries; power of two, >= 2
//   ADDR_W  32  width of pc field
//   INST_W  32  width of instruction field
//   EXC_W   8   width of exception-code field (bit7 = fetch address error)
//   AFULL   3   occupancy at or above which afull asserts; 1..DEPTH
// PORTS
//   clk            in   1                   clock, all state updates on posedge
//   rst            in   1                   synchronous reset, active-low (rst==0 resets)
//   flush          in   1                   discard all entries (redirect / exception)
//   in_valid       in   1                   fetch offers an entry
//   in_ready       out  1                   queue accepts an entry this cycle
//   in_pc          in   ADDR_W              pc of offered instruction
//   in_instr       in   INST_W              instruction word
//   in_exc         in   EXC_W               fetch-stage exception bits
//   in_ds          in   1                   entry is in a branch delay slot
//   out_valid      out  1                   head entry valid for decode
//   out_ready      in   1                   decode consumes head (~stallD)
//   out_pc         out  ADDR_W              head pc
//   out_instr      out  INST_W              head instruction
//   out_exc        out  EXC_W               head exception bits
//   out_ds         out  1                   head delay-slot flag
//   count          out  $clog2(DEPTH)+1     current occupancy
//   afull          out  1                   count >= AFULL
// BEHAVIOUR
//   Reset:
//   - while rst==0 at posedge: wptr=rptr=0, count=0; storage cleared to 0.
//   - reset values: out_valid=0, in_ready=1, afull=0, out_pc/out_instr/out_exc/out_ds=0.
//   - a reset asserted mid-operation discards all entries the same as at start-up.
//   Handshakes:
//   - in_ready = (count != DEPTH). It depends only on registered state and has no combinational path from out_ready.
//   - push = in_valid & in_ready & ~flush.
//   - pop = out_valid & out_ready & ~flush.
//   Data path:
//   - out_valid = (count != 0).
//   - out_* = mem[rptr] combinationally, so the head is visible with no read latency.
//   - write latency is 1: an entry pushed at edge N is presented on out_* after edge N, valid from cycle N+1.
//   - there is no empty-bypass.
//   Pointers and occupancy:
//   - pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   - count is tracked separately, so full and empty are unambiguous.
//   - push & pop in the same cycle: both pointers advance and count is unchanged. This is legal at any occupancy 1..DEPTH-1.
//   - full (count==DEPTH): in_ready=0 and in_valid is ignored. A pop in that cycle frees a slot, but a new push is accepted only next cycle.
//   - empty: out_ready is ignored and no pointer moves.
//   Flush:
//   - flush has priority over push and pop.
//   - at the next edge, wptr=rptr=0 and count=0.
//   - a concurrent push is dropped and a concurrent pop does not occur.
//   - storage contents are left unchanged; out_* then shows the stale mem[0] with out_valid=0.
//   - flush while empty is a no-op apart from pointer reset.
//   - flush held over several cycles keeps the queue empty.
//   Entry integrity and flags:
//   - entries are never reordered, duplicated or partially written; all fields of an entry move together.
//   - afull is a registered-state function: count >= AFULL.
// TESTING
//   1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, afull=0, out_instr=0.
//   2. Fill/drain (DEPTH=4, out_ready=0):
//      - push pc 0x100,0x104,0x108,0x10C -> count=4, in_ready=0, afull=1 from count 3; push of 0x110 is not accepted.
//      - then out_ready=1 -> out_pc 0x100,0x104,0x108,0x10C on consecutive cycles, then out_valid=0.
//   3. Streaming: in_valid=out_ready=1 for 20 cycles with pc +4 each cycle -> count holds at 1 after first push; out_pc trails in_pc by 1 cycle with no gaps; pointers wrap 5 times.
//   4. Flush with push: count=3, assert flush together with in_valid for pc 0x200 -> next cycle count=0, out_valid=0; 0x200 never appears on out_pc.
//   5. Full plus pop: count=4, out_ready=1, in_valid=1 -> pop occurs, push is refused (count=3); the following cycle the push is accepted (count stays 3 with pop).
//   6. Field integrity: push in_exc=8'h80, in_ds=1, in_instr=32'h0000000C -> appears intact on out_exc/out_ds/out_instr; reset mid-stream (count=2) -> queue empty next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode: DEPTH entries of {pc, instr, exc, ds},
// zero-latency head read, single-cycle flush on redirect or trap.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 8,
    parameter int AFULL  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [INST_W-1:0]          in_instr,
    input  logic [EXC_W-1:0]           in_exc,
    input  logic                       in_ds,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INST_W-1:0]          out_instr,
    output logic [EXC_W-1:0]           out_exc,
    output logic                       out_ds,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       afull
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL);

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d    [DEPTH];
    logic [INST_W-1:0] instr_mem_q [DEPTH];
    logic [INST_W-1:0] instr_mem_d [DEPTH];
    logic [EXC_W-1:0]  exc_mem_q   [DEPTH];
    logic [EXC_W-1:0]  exc_mem_d   [DEPTH];
    logic              ds_mem_q    [DEPTH];
    logic              ds_mem_d    [DEPTH];

    logic push;
    logic pop;

    // in_ready and out_valid come only from registered occupancy, so no ready path crosses the queue.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_pc    = pc_mem_q[rptr_q];
    assign out_instr = instr_mem_q[rptr_q];
    assign out_exc   = exc_mem_q[rptr_q];
    assign out_ds    = ds_mem_q[rptr_q];
    assign count     = count_q;
    assign afull     = (count_q >= AFULL_CNT);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        exc_mem_d   = exc_mem_q;
        ds_mem_d    = ds_mem_q;

        if (flush) begin
            // Storage is left as is; only the bookkeeping is cleared.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_mem_d[wptr_q]    = in_pc;
                instr_mem_d[wptr_q] = in_instr;
                exc_mem_d[wptr_q]   = in_exc;
                ds_mem_d[wptr_q]    = in_ds;
                wptr_d              = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
                exc_mem_q[i]   <= '0;
                ds_mem_q[i]    <= 1'b0;
            end
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            exc_mem_q   <= exc_mem_d;
            ds_mem_q    <= ds_mem_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int EXC_W  = 8;
    localparam int AFULL  = 3;
    localparam int W      = ADDR_W + INST_W + EXC_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_instr;
    logic [EXC_W-1:0]  in_exc;
    logic              in_ds;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_instr;
    logic [EXC_W-1:0]  out_exc;
    logic              out_ds;
    logic [$clog2(DEPTH):0] count;
    logic              afull;

    logic [W-1:0] exp_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  started = 0;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W), .EXC_W(EXC_W), .AFULL(AFULL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc), .in_ds(in_ds),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .out_ds(out_ds),
        .count(count), .afull(afull)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", name, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] ins,
                         input logic [EXC_W-1:0] exc, input logic ds, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        in_exc    = exc;
        in_ds     = ds;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic push_pc(input logic [ADDR_W-1:0] pc, input logic ordy);
        drive(1'b1, pc, ~pc, EXC_W'(pc), pc[2], ordy, 1'b0);
        tick();
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, '0, '0, 1'b0, ordy, 1'b0);
            tick();
        end
    endtask

    // Monitor + reference model: compare what the DUT presents, then apply the cycle's rules
    // to the expected queue (reset/flush empty it, pops take the head, accepted pushes append).
    always @(negedge clk) begin
        if (started) begin
            int n;
            n = exp_q.size();
            chk("count",     W'(count),     W'(n));
            chk("out_valid", W'(out_valid), W'(n != 0));
            chk("in_ready",  W'(in_ready),  W'(n != DEPTH));
            chk("afull",     W'(afull),     W'(n >= AFULL));
            if (n != 0)
                chk("head", {out_pc, out_instr, out_exc, out_ds}, exp_q[0]);
            if (!rst || flush) begin
                exp_q.delete();
            end else begin
                if (n != 0 && out_ready)
                    void'(exp_q.pop_front());
                if (in_valid && n != DEPTH)
                    exp_q.push_back({in_pc, in_instr, in_exc, in_ds});
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 8'hFF, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        started = 1;
        #1;
        tick();
        // reset: storage cleared, so the stale head reads as zero
        chk("rst_out_instr", W'(out_instr), '0);
        chk("rst_out_pc",    W'(out_pc),    '0);
        chk("rst_out_exc",   W'(out_exc),   '0);
        chk("rst_out_ds",    W'(out_ds),    '0);
        rst = 1'b1;
        idle(1'b0, 1);

        // fill to full then drain
        for (int i = 0; i < 5; i++) push_pc(32'h100 + 32'(4 * i), 1'b0);
        idle(1'b1, 6);

        // streaming
        for (int i = 0; i < 20; i++) push_pc(32'h1000 + 32'(4 * i), 1'b1);
        idle(1'b1, 2);

        // flush together with a push
        for (int i = 0; i < 3; i++) push_pc(32'h180 + 32'(4 * i), 1'b0);
        drive(1'b1, 32'h200, 32'hCAFE_0200, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        idle(1'b1, 3);

        // full plus pop: push refused in the pop cycle, accepted the next
        for (int i = 0; i < 4; i++) push_pc(32'h300 + 32'(4 * i), 1'b0);
        push_pc(32'h310, 1'b1);
        push_pc(32'h310, 1'b1);
        idle(1'b1, 5);

        // field integrity, then reset mid-stream at count=2
        drive(1'b1, 32'h400, 32'h0000_000C, 8'h80, 1'b1, 1'b0, 1'b0);
        tick();
        push_pc(32'h404, 1'b0);
        chk("fi_count", W'(count), W'(2));
        rst = 1'b0;
        idle(1'b0, 1);
        rst = 1'b1;
        idle(1'b1, 2);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            rst = ($urandom_range(0, 63) != 0);
            tick();
        end
        rst = 1'b1;
        idle(1'b1, DEPTH + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
